// File: rtl/iob_eth_tx_framer.sv
// iob_eth_tx_framer: sequences preamble, SFD, payload, pad, FCS and IFG onto the MII byte stream
module iob_eth_tx_framer #(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_LEN     = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        crc_start,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_in,
    output logic        busy,
    output logic        frame_done
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, PAYLOAD, PAD, FCS, IFG} state_t;
    localparam logic [10:0] MIN_LEN = 11'(MIN_PAYLOAD);
    localparam logic [7:0]  IFG_END = 8'(IFG_LEN - 1);
    state_t      state;
    logic [10:0] cnt, cnt_inc;
    logic [7:0]  sub, fcs_byte;
    logic [31:0] fcs, fcs_word;
    logic        fcs_loaded, accept, feed;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
    endfunction

    // crc_in already holds the final value on the first FCS cycle; later cycles use the latched copy
    assign fcs_word   = fcs_loaded ? fcs : crc_in;
    assign fcs_byte   = 8'(fcs_word >> {~sub[1:0], 3'b000});
    assign busy       = state != IDLE;
    assign feed       = state == PAYLOAD || state == PAD;
    assign in_ready   = state == PAYLOAD && tx_ready;
    assign tx_valid   = state inside {PRE, SFD, PAD, FCS} || (state == PAYLOAD && in_valid);
    assign tx_data    = state == PRE     ? 8'h55 :
                        state == SFD     ? 8'hD5 :
                        state == PAYLOAD ? in_data :
                        state == FCS     ? ~bitrev8(fcs_byte) : 8'h00;
    assign accept     = tx_valid && tx_ready;
    assign crc_en     = accept && feed;
    assign crc_data   = feed ? bitrev8(tx_data) : 8'h00;
    assign crc_start  = rst_n && state == IDLE && in_valid;
    assign frame_done = state == FCS && accept && sub == 8'd3;
    assign cnt_inc    = &cnt ? cnt : cnt + 11'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sub        <= '0;
            fcs        <= '0;
            fcs_loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    sub        <= '0;
                    fcs_loaded <= 1'b0;
                    if (in_valid) state <= PRE;
                end
                PRE: if (accept) begin
                    sub <= sub == 8'd6 ? 8'd0 : sub + 8'd1;
                    if (sub == 8'd6) state <= SFD;
                end
                SFD: if (accept) state <= PAYLOAD;
                PAYLOAD: if (accept) begin
                    cnt <= cnt_inc;
                    if (in_last) begin
                        if (cnt_inc < MIN_LEN) state <= PAD;
                        else state <= FCS;
                    end
                end
                PAD: if (accept) begin
                    cnt <= cnt_inc;
                    if (cnt_inc >= MIN_LEN) state <= FCS;
                end
                FCS: begin
                    if (!fcs_loaded) fcs <= crc_in;
                    fcs_loaded <= 1'b1;
                    if (accept) begin
                        sub <= sub == 8'd3 ? 8'd0 : sub + 8'd1;
                        if (sub == 8'd3) state <= IFG;
                    end
                end
                IFG: begin
                    sub <= sub == IFG_END ? 8'd0 : sub + 8'd1;
                    if (sub == IFG_END) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_eth_tx_framer.sv
// tb_iob_eth_tx_framer: vector table and random frames checked against a reflected CRC-32 frame model
module tb_iob_eth_tx_framer;
    typedef struct {bit sel; int len; int rdy; int gp; int total; int en;} vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, tx_ready = 1'b0;
    logic        in_ready0, tx_valid0, crc_start0, crc_en0, busy0, frame_done0;
    logic        in_ready1, tx_valid1, crc_start1, crc_en1, busy1, frame_done1;
    logic [7:0]  tx_data0, crc_data0, tx_data1, crc_data1;
    logic [31:0] crc0, crc1;
    logic        o_in_ready, o_tx_valid, o_crc_start, o_crc_en, o_busy, o_frame_done;
    logic [7:0]  o_tx_data, o_crc_data;

    int checks = 0, errors = 0, cyc_no = 0, start_cyc = 0;
    int en_cnt, cs_cnt, done_cnt, done_idx, first_v, last_v, last_done, gap_cyc, stall_err;
    logic       prev_stall, took;
    logic [7:0] prev_data;
    logic [7:0] out_q[$], exp_q[$];

    always #5 clk = ~clk;

    iob_eth_tx_framer u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && !sel), .in_last(in_last),
        .in_ready(in_ready0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .crc_start(crc_start0), .crc_en(crc_en0), .crc_data(crc_data0), .crc_in(crc0),
        .busy(busy0), .frame_done(frame_done0)
    );

    iob_eth_tx_framer #(.MIN_PAYLOAD(0), .IFG_LEN(1)) u_nopad (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && sel), .in_last(in_last),
        .in_ready(in_ready1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .crc_start(crc_start1), .crc_en(crc_en1), .crc_data(crc_data1), .crc_in(crc1),
        .busy(busy1), .frame_done(frame_done1)
    );

    assign o_in_ready   = sel ? in_ready1 : in_ready0;
    assign o_tx_valid   = sel ? tx_valid1 : tx_valid0;
    assign o_tx_data    = sel ? tx_data1 : tx_data0;
    assign o_crc_start  = sel ? crc_start1 : crc_start0;
    assign o_crc_en     = sel ? crc_en1 : crc_en0;
    assign o_crc_data   = sel ? crc_data1 : crc_data0;
    assign o_busy       = sel ? busy1 : busy0;
    assign o_frame_done = sel ? frame_done1 : frame_done0;

    // stand-in for the shared MSB-first iob_eth_crc register
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r = c;
        for (int i = 7; i >= 0; i--) r = (r[31] ^ d[i]) ? (r << 1) ^ 32'h04C11DB7 : r << 1;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc0 <= '0;
        else if (crc_start0) crc0 <= '1;
        else if (crc_en0) crc0 <= crc_step(crc0, crc_data0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc1 <= '0;
        else if (crc_start1) crc1 <= '1;
        else if (crc_en1) crc1 <= crc_step(crc1, crc_data1);

    function automatic logic [31:0] crc32_ref(input logic [7:0] d[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c ^= {24'h0, d[i]};
            repeat (8) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    task automatic add_exp(input logic [7:0] p[$], input int minp);
        logic [7:0] f[$];
        logic [31:0] r;
        f = p;
        while (f.size() < minp) f.push_back(8'h00);
        r = crc32_ref(f);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (f[i]) exp_q.push_back(f[i]);
        for (int k = 0; k < 4; k++) exp_q.push_back(r[8*k +: 8]);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic clear_mon();
        out_q.delete();
        exp_q.delete();
        en_cnt = 0; cs_cnt = 0; done_cnt = 0; done_idx = -1; first_v = -1; last_v = -1;
        last_done = -1; gap_cyc = -1; stall_err = 0; prev_stall = 1'b0;
    endtask

    // called at a falling edge after driving inputs; observes what the next rising edge commits
    task automatic cyc();
        #1;
        took = in_valid && o_in_ready;
        if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) stall_err++;
        prev_stall = o_tx_valid && !tx_ready;
        prev_data = o_tx_data;
        if (o_tx_valid) begin
            if (first_v < 0) first_v = cyc_no;
            last_v = cyc_no;
            if (gap_cyc < 0 && last_done >= 0) gap_cyc = cyc_no - last_done - 1;
        end
        if (o_tx_valid && tx_ready) out_q.push_back(o_tx_data);
        if (o_frame_done) begin
            done_cnt++;
            done_idx = out_q.size() - 1;
            last_done = cyc_no;
        end
        if (o_crc_en) en_cnt++;
        if (o_crc_start) cs_cnt++;
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic tail(input int n);
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; tx_ready = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic run_stream(input logic [7:0] p[$], input bit l[$], input int nf,
                              input int rdy, input int gp, input string nm);
        int idx = 0;
        int t = 0;
        bit pend = 1'b0;
        start_cyc = cyc_no;
        while (done_cnt < nf && t < 5000) begin
            in_valid = idx < p.size() && (pend || idx == 0 || $urandom_range(99) >= gp);
            in_data  = idx < p.size() ? p[idx] : 8'h00;
            in_last  = idx < p.size() && l[idx];
            tx_ready = $urandom_range(99) < rdy;
            cyc();
            pend = in_valid && !took;
            if (took) idx++;
            t++;
        end
        chk({nm, "_timeout"}, int'(done_cnt < nf), 0);
    endtask

    task automatic chk_stream(input string nm);
        int bad = -1;
        chk({nm, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        chk({nm, "_first_bad_byte"}, bad, -1);
    endtask

    task automatic do_vec(input vec_t v, input int n);
        logic [7:0] p[$];
        bit l[$];
        string nm = $sformatf("vec%0d", n);
        sel = v.sel;
        for (int i = 0; i < v.len; i++) begin
            p.push_back(8'($urandom));
            l.push_back(i == v.len - 1);
        end
        clear_mon();
        add_exp(p, v.sel ? 0 : 60);
        run_stream(p, l, 1, v.rdy, v.gp, nm);
        chk({nm, "_total"}, out_q.size(), v.total);
        chk_stream(nm);
        chk({nm, "_crc_en"}, en_cnt, v.en);
        chk({nm, "_crc_start"}, cs_cnt, 1);
        chk({nm, "_done_idx"}, done_idx, v.total - 1);
        chk({nm, "_latency"}, first_v - start_cyc, 1);
        chk({nm, "_stall_hold"}, stall_err, 0);
        if (v.rdy == 100 && v.gp == 0) chk({nm, "_span"}, last_v - first_v + 1, v.total);
        tail(v.sel ? 3 : 14);
        chk({nm, "_idle"}, int'(o_busy), 0);
    endtask

    initial begin
        vec_t vt[8];
        logic [7:0] p[$];
        bit l[$];
        logic [7:0] kc[4];
        vt[0] = '{1'b0, 1, 100, 0, 72, 60};
        vt[1] = '{1'b0, 59, 100, 0, 72, 60};
        vt[2] = '{1'b0, 60, 100, 0, 72, 60};
        vt[3] = '{1'b0, 61, 100, 0, 73, 61};
        vt[4] = '{1'b0, 64, 50, 30, 76, 64};
        vt[5] = '{1'b0, 64, 100, 0, 76, 64};
        vt[6] = '{1'b1, 1, 100, 0, 13, 1};
        vt[7] = '{1'b1, 20, 60, 40, 32, 20};
        kc = '{8'h26, 8'h39, 8'hF4, 8'hCB};

        in_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_outputs", int'({o_tx_valid, o_in_ready, o_crc_start, o_crc_en, o_busy,
                                   o_frame_done, o_tx_data, o_crc_data}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tail(2);

        foreach (vt[i]) do_vec(vt[i], i);

        // known CRC-32 check value of "123456789"
        sel = 1'b1;
        clear_mon();
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        l.delete();
        foreach (p[i]) l.push_back(i == 8);
        add_exp(p, 0);
        run_stream(p, l, 1, 100, 0, "known");
        chk("known_total", out_q.size(), 21);
        chk("known_crc_en", en_cnt, 9);
        chk("known_done_idx", done_idx, 20);
        for (int k = 0; k < 4; k++) chk($sformatf("known_fcs%0d", k), int'(out_q[17 + k]), int'(kc[k]));
        chk_stream("known");
        tail(3);

        // back-to-back frames with in_valid held high
        sel = 1'b0;
        clear_mon();
        p.delete();
        l.delete();
        for (int i = 0; i < 75; i++) begin
            p.push_back(8'($urandom));
            l.push_back(i == 9 || i == 74);
        end
        add_exp(p[0:9], 60);
        add_exp(p[10:74], 60);
        run_stream(p, l, 2, 100, 0, "b2b");
        chk_stream("b2b");
        chk("b2b_crc_start", cs_cnt, 2);
        chk("b2b_done", done_cnt, 2);
        chk("b2b_gap", gap_cyc, 13);
        tail(14);

        // asynchronous reset mid-payload
        clear_mon();
        in_valid = 1'b1; in_last = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i + 1);
            cyc();
        end
        chk("rst_mid_busy", int'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({o_tx_valid, o_in_ready, o_crc_start, o_crc_en, o_busy,
                                     o_frame_done, o_tx_data, o_crc_data}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tail(3);
        chk("rst_after_busy", int'(o_busy), 0);
        do_vec(vt[5], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule
